// File: rtl/vga_sync_rx.sv
// VGA timing receiver: measures hsync/vsync against the nominal raster, locks after
// a run of clean frames and then emits active pixels with their coordinates.
module vga_sync_rx #(
    parameter int H_SYNC        = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int H_VALID_STATE = 640,
    parameter int H_TOTAL       = 800,
    parameter int V_SYNC        = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int V_VALID_STATE = 480,
    parameter int V_TOTAL       = 525,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] rgb,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic        sof,
    output logic        locked,
    output logic        timing_err
);

    localparam int H_START = H_SYNC + H_BACK_PORCH;
    localparam int H_END   = H_START + H_VALID_STATE;
    localparam int V_START = V_SYNC + V_BACK_PORCH;
    localparam int V_END   = V_START + V_VALID_STATE;
    localparam int GW      = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
    localparam logic [10:0] H_START_W = 11'(H_START);
    localparam logic [10:0] H_END_W   = 11'(H_END);
    localparam logic [10:0] V_START_W = 11'(V_START);
    localparam logic [10:0] V_END_W   = 11'(V_END);
    localparam logic [GW-1:0] LOCK_W  = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state;
    logic [GW-1:0]  good;
    logic           dirty;
    logic           hs1;
    logic           vs1;
    logic [23:0]    rgb1;
    logic [9:0]     h_cnt;
    logic [9:0]     v_cnt;

    logic           h_rise;
    logic           h_fall;
    logic           v_rise;
    logic           v_fall;
    logic [10:0]    h_cnt_p1;
    logic [10:0]    v_cnt_p1;
    logic           viol;
    logic           act;
    logic           at_origin;

    // Edges compare the raw pin with the stage-1 copy, so they line up with the
    // cycle in which rgb1 is about to take the first sample of the new line.
    assign h_rise = hsync & ~hs1;
    assign h_fall = ~hsync & hs1;
    assign v_rise = vsync & ~vs1;
    assign v_fall = ~vsync & vs1;

    assign h_cnt_p1 = {1'b0, h_cnt} + 11'd1;
    assign v_cnt_p1 = {1'b0, v_cnt} + 11'd1;

    always_comb begin
        viol = 1'b0;
        if (h_rise && (h_cnt_p1 != H_TOTAL_W)) viol = 1'b1;
        if (h_fall && (h_cnt_p1 != H_SYNC_W))  viol = 1'b1;
        if (v_rise && ((v_cnt_p1 != V_TOTAL_W) || !h_rise)) viol = 1'b1;
        if (v_fall && (v_cnt_p1 != V_SYNC_W))  viol = 1'b1;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            rgb1 <= 24'd0;
        end else begin
            hs1  <= hsync;
            vs1  <= vsync;
            rgb1 <= rgb;
        end
    end

    // Counters saturate so a missing sync is reported by the next check instead
    // of silently wrapping back into range.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else begin
            if (h_rise) begin
                h_cnt <= 10'd0;
            end else if (h_cnt != 10'h3ff) begin
                h_cnt <= h_cnt + 10'd1;
            end

            if (v_rise) begin
                v_cnt <= 10'd0;
            end else if (h_rise && (v_cnt != 10'h3ff)) begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // dirty remembers a violation earlier in the current frame so the closing
    // v_rise does not count that frame towards lock.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= SEARCH;
            good       <= '0;
            dirty      <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_rise) begin
                        state <= TRAIN;
                        good  <= '0;
                        dirty <= 1'b0;
                    end
                end
                TRAIN: begin
                    if (viol) begin
                        good       <= '0;
                        dirty      <= ~v_rise;
                        timing_err <= 1'b1;
                    end else if (v_rise) begin
                        if (dirty) begin
                            good  <= '0;
                            dirty <= 1'b0;
                        end else if ((good + 1'b1) >= LOCK_W) begin
                            good   <= good + 1'b1;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            good <= good + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (viol) begin
                        state      <= SEARCH;
                        good       <= '0;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    good   <= '0;
                    dirty  <= 1'b0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign act = (state == LOCKED) &&
                 ({1'b0, h_cnt} >= H_START_W) && ({1'b0, h_cnt} < H_END_W) &&
                 ({1'b0, v_cnt} >= V_START_W) && ({1'b0, v_cnt} < V_END_W);
    assign at_origin = ({1'b0, h_cnt} == H_START_W) && ({1'b0, v_cnt} == V_START_W);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            pix_data  <= 24'd0;
            pos_x     <= 10'h3ff;
            pos_y     <= 10'h3ff;
        end else begin
            pix_valid <= act;
            sof       <= act & at_origin;
            pix_data  <= act ? rgb1 : 24'd0;
            pos_x     <= act ? (h_cnt - H_START_W[9:0]) : 10'h3ff;
            pos_y     <= act ? (v_cnt - V_START_W[9:0]) : 10'h3ff;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a shrunken raster: a directed vector table, directed
// lock/fault sequences, then random frames checked every cycle against a raster model.
module tb_vga_sync_rx;

  localparam int HS  = 4;
  localparam int HBP = 3;
  localparam int HV  = 8;
  localparam int HT  = 20;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int VV  = 4;
  localparam int VT  = 10;
  localparam int LF  = 2;
  localparam int H_START = HS + HBP;
  localparam int V_START = VS + VBP;

  localparam int M_SEARCH = 0;
  localparam int M_TRAIN  = 1;
  localparam int M_LOCKED = 2;

  logic        vga_clk;
  logic        sys_rst_n;
  logic        hsync;
  logic        vsync;
  logic [23:0] rgb;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        sof;
  logic        locked;
  logic        timing_err;

  vga_sync_rx #(
    .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_VALID_STATE(HV), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_VALID_STATE(VV), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) u_dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pos_x(pos_x), .pos_y(pos_y), .pix_valid(pix_valid), .pix_data(pix_data),
    .sof(sof), .locked(locked), .timing_err(timing_err)
  );

  // clock / reset
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // monitors, sampled on the falling edge
  int err_cnt   = 0;
  int valid_cnt = 0;
  int sof_cnt   = 0;
  logic [45:0] sof_word = '0;
  always @(negedge vga_clk) begin
    if (timing_err) err_cnt <= err_cnt + 1;
    if (pix_valid)  valid_cnt <= valid_cnt + 1;
    if (sof) begin
      sof_cnt  <= sof_cnt + 1;
      sof_word <= {pix_valid, sof, pos_x, pos_y, pix_data};
    end
  end

  // reference model: positions from time since last hsync rise, lines since last
  // vsync rise; checks are periods/pulse widths of the sync signals.
  logic [45:0] exp_q[$];
  int   m_t, m_th, m_lines, m_mode, m_clean;
  bit   m_dirty, m_phs, m_pvs;

  function automatic int clamp10(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  function automatic logic [45:0] idle_word();
    return {1'b0, 1'b0, 10'h3ff, 10'h3ff, 24'd0};
  endfunction

  task automatic model_reset();
    m_th = m_t; m_lines = 0; m_mode = M_SEARCH; m_clean = 0;
    m_dirty = 0; m_phs = 0; m_pvs = 0;
    exp_q.delete();
    exp_q.push_back(idle_word());
  endtask

  task automatic model_sample(input logic hs, input logic vs, input logic [23:0] c,
                              output logic e_err, output logic e_lock);
    bit hr, hf, vr, vf, viol, act;
    int pre_pos, pos;
    m_t++;
    hr = hs && !m_phs; hf = !hs && m_phs;
    vr = vs && !m_pvs; vf = !vs && m_pvs;
    pre_pos = clamp10(m_t - 1 - m_th);
    viol = 0;
    if (hr && (pre_pos + 1 != HT)) viol = 1;
    if (hf && (pre_pos + 1 != HS)) viol = 1;
    if (vr && ((m_lines + 1 != VT) || !hr)) viol = 1;
    if (vf && (m_lines + 1 != VS)) viol = 1;
    e_err = 0;
    if (m_mode == M_SEARCH) begin
      if (vr) begin m_mode = M_TRAIN; m_clean = 0; m_dirty = 0; end
    end else if (m_mode == M_TRAIN) begin
      if (viol) begin
        e_err = 1; m_clean = 0; m_dirty = !vr;
      end else if (vr) begin
        if (m_dirty) begin m_clean = 0; m_dirty = 0; end
        else begin
          m_clean++;
          if (m_clean >= LF) m_mode = M_LOCKED;
        end
      end
    end else begin
      if (viol) begin e_err = 1; m_mode = M_SEARCH; end
    end
    if (hr) m_th = m_t;
    if (vr) m_lines = 0;
    else if (hr) m_lines = clamp10(m_lines + 1);
    pos = clamp10(m_t - m_th);
    act = (m_mode == M_LOCKED) && (pos >= H_START) && (pos < H_START + HV) &&
          (m_lines >= V_START) && (m_lines < V_START + VV);
    exp_q.push_back({act, act && (pos == H_START) && (m_lines == V_START),
                     act ? 10'(pos - H_START) : 10'h3ff,
                     act ? 10'(m_lines - V_START) : 10'h3ff,
                     act ? c : 24'd0});
    m_phs = hs; m_pvs = vs;
    e_lock = (m_mode == M_LOCKED);
  endtask

  // driver tasks
  task automatic step(input logic hs, input logic vs, input logic [23:0] c);
    logic e_err, e_lock;
    logic [45:0] w;
    hsync = hs; vsync = vs; rgb = c;
    model_sample(hs, vs, c, e_err, e_lock);
    @(posedge vga_clk); #1;
    check("timing_err", 64'(timing_err), 64'(e_err));
    check("locked", 64'(locked), 64'(e_lock));
    w = exp_q.pop_front();
    check("pix{valid,sof,x,y,data}", 64'({pix_valid, sof, pos_x, pos_y, pix_data}), 64'(w));
  endtask

  task automatic gen_line(input int len, input int hsw, input logic vs_on, input int y);
    for (int i = 0; i < len; i++)
      step(i < hsw, vs_on, (i == H_START && y == V_START) ? 24'hA5A5A5 : 24'($urandom));
  endtask

  // kind: 0 clean, 1 long line, 2 short hsync, 3 short line, 4 extra line
  task automatic gen_frame(input int bad_line, input int kind);
    int nl, len, hsw;
    nl = (kind == 4) ? VT + 1 : VT;
    for (int y = 0; y < nl; y++) begin
      len = HT; hsw = HS;
      if (y == bad_line) begin
        if (kind == 1) len = HT + 1;
        if (kind == 2) hsw = HS - 1;
        if (kind == 3) len = HT - 1;
      end
      gen_line(len, hsw, y < VS, y);
    end
  endtask

  task automatic do_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst pix_valid", 64'(pix_valid), 64'(0));
    check("rst sof/locked/err", 64'({sof, locked, timing_err}), 64'(0));
    check("rst pix_data", 64'(pix_data), 64'(0));
    check("rst pos_x", 64'(pos_x), 64'(10'h3ff));
    check("rst pos_y", 64'(pos_y), 64'(10'h3ff));
    repeat (3) @(posedge vga_clk);
    #1;
    model_reset();
    sys_rst_n = 1'b1;
  endtask

  // two frames leave the block training, the third v_rise locks it
  task automatic lock_seq(input string tag);
    gen_frame(-1, 0);
    gen_frame(-1, 0);
    check({tag, " locked before 3rd v_rise"}, 64'(locked), 64'(0));
    gen_frame(-1, 0);
    check({tag, " locked after 3rd v_rise"}, 64'(locked), 64'(1));
  endtask

  typedef struct {
    logic        rst_n;
    logic        hs;
    logic        vs;
    logic [23:0] c;
    logic        e_err;
    logic        e_valid;
    logic        e_lock;
    logic [9:0]  e_x;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int e0, v0, s0;
    sys_rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
    m_t = 0;

    // SEARCH ignores nonsense syncs; the first v_rise arms checking.
    tbl[0] = '{1'b0, 1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 24'hffffff, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 24'habcdef, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 24'h111111, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 24'h222222, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 24'h333333, 1'b1, 1'b0, 1'b0, 10'h3ff};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 24'h444444, 1'b1, 1'b0, 1'b0, 10'h3ff};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 24'h555555, 1'b0, 1'b0, 1'b0, 10'h3ff};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 24'h666666, 1'b1, 1'b0, 1'b0, 10'h3ff};

    for (int i = 0; i < 10; i++) begin
      sys_rst_n = tbl[i].rst_n; hsync = tbl[i].hs; vsync = tbl[i].vs; rgb = tbl[i].c;
      @(posedge vga_clk); #1;
      check($sformatf("tbl[%0d] timing_err", i), 64'(timing_err), 64'(tbl[i].e_err));
      check($sformatf("tbl[%0d] pix_valid", i), 64'(pix_valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl[%0d] locked", i), 64'(locked), 64'(tbl[i].e_lock));
      check($sformatf("tbl[%0d] pos_x", i), 64'(pos_x), 64'(tbl[i].e_x));
      check($sformatf("tbl[%0d] pix_data", i), 64'(pix_data), 64'(0));
    end

    // clean timing locks at the third v_rise; first active pixel carries A5A5A5
    do_reset();
    e0 = err_cnt; s0 = sof_cnt;
    lock_seq("clean");
    #4;
    check("clean no timing_err", 64'(err_cnt - e0), 64'(0));
    check("sof seen in locked frame", 64'(sof_cnt - s0), 64'(1));
    check("sof word", 64'(sof_word), 64'({1'b1, 1'b1, 10'd0, 10'd0, 24'hA5A5A5}));

    // one 21-pixel line while locked
    e0 = err_cnt;
    gen_frame(5, 1);
    check("long line err pulses", 64'(err_cnt - e0), 64'(1));
    check("long line unlocked", 64'(locked), 64'(0));
    lock_seq("relock");

    // reset mid-line while locked
    gen_line(HT, HS, 1'b1, 0);
    gen_line(10, HS, 1'b1, 1);
    do_reset();
    lock_seq("post-reset");

    // short hsync in the first training frame clears progress
    do_reset();
    e0 = err_cnt;
    gen_frame(3, 2);
    check("short hsync err pulses", 64'(err_cnt - e0), 64'(1));
    gen_frame(-1, 0);
    gen_frame(-1, 0);
    check("short hsync still training", 64'(locked), 64'(0));
    gen_frame(-1, 0);
    check("short hsync relocked", 64'(locked), 64'(1));

    // hsync outage: counter saturates, error at the next h_rise
    e0 = err_cnt; v0 = valid_cnt;
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b0, 24'($urandom));
    #4;
    check("outage no pix_valid", 64'(valid_cnt - v0), 64'(0));
    check("outage no err yet", 64'(err_cnt - e0), 64'(0));
    check("outage dut h_cnt saturated", 64'(u_dut.h_cnt), 64'(10'h3ff));
    gen_frame(-1, 0);
    check("outage err pulses", 64'(err_cnt - e0), 64'(1));

    // random frames with occasional faults
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) gen_frame($urandom_range(0, VT - 1), $urandom_range(1, 4));
      else gen_frame(-1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- H_SYNC, 96, hsync width in pixels
- H_BACK_PORCH, 48, pixels from end of hsync to first active pixel
- H_VALID_STATE, 640, active pixels per line
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, vsync width in lines
- V_BACK_PORCH, 33, lines from end of vsync to first active line
- V_VALID_STATE, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to lock
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- vga_clk, in, 1, pixel clock; one clock domain; all inputs synchronous to it
- sys_rst_n, in, 1, asynchronous active-low reset
- hsync, in, 1, active-high horizontal sync
- vsync, in, 1, active-high vertical sync
- rgb, in, 24, pixel colour
- pos_x, out, 10, active column 0..639, 10'h3ff when not valid
- pos_y, out, 10, active row 0..479, 10'h3ff when not valid
- pix_valid, out, 1, pix_data/pos_x/pos_y carry an active pixel
- pix_data, out, 24, captured pixel, 0 when not valid
- sof, out, 1, one-cycle pulse with pixel (0,0)
- locked, out, 1, timing lock achieved
- timing_err, out, 1, one-cycle pulse on timing violation in TRAIN or LOCKED

Function
REQ-003 Input stage: hsync, vsync, rgb SHALL be registered every clock into hs1, vs1, rgb1.
REQ-004 Edges SHALL be detected on the raw input against stage 1: h_rise = hsync & ~hs1; h_fall = ~hsync & hs1; v_rise and v_fall likewise.
REQ-005 h_cnt (10 bit) SHALL load 0 on h_rise and otherwise increment, saturating at 1023; h_cnt always equals the line position of the sample in rgb1.
REQ-006 v_cnt (10 bit) SHALL load 0 on v_rise, else increment on h_rise, saturating at 1023; v_rise takes priority over a simultaneous h_rise.
REQ-007 Checks SHALL use pre-update counter values and apply only in TRAIN and LOCKED:
- on h_rise, require h_cnt+1 == H_TOTAL
- on h_fall, require h_cnt+1 == H_SYNC
- on v_rise, require v_cnt+1 == V_TOTAL, and require h_rise in the same cycle
- on v_fall, require v_cnt+1 == V_SYNC
REQ-008 State machine SHALL have three states:
- SEARCH: on v_rise -> TRAIN, good=0.
- TRAIN: any violation -> good=0, stay in TRAIN, timing_err pulse. On a clean v_rise, good increments; when good reaches LOCK_FRAMES -> LOCKED.
- LOCKED: any violation -> SEARCH with a timing_err pulse.
REQ-009 A frame SHALL count as clean only if no violation occurred between consecutive v_rise events; the v_rise cycle's own checks are included.
REQ-010 locked SHALL be registered and equal 1 exactly while the state is LOCKED.
REQ-011 Output stage SHALL be registered: act = LOCKED & h_cnt in [144,784) & v_cnt in [35,515), using H_SYNC+H_BACK_PORCH and V_SYNC+V_BACK_PORCH. Next cycle:
- pix_valid = act
- pix_data = act ? rgb1 : 0
- pos_x = act ? h_cnt-144 : 10'h3ff
- pos_y = act ? v_cnt-35 : 10'h3ff
REQ-012 Latency: an input sample SHALL appear on the outputs exactly 2 vga_clk edges after it is presented.
REQ-013 sof SHALL equal act & (h_cnt == 144) & (v_cnt == 35), registered alongside pix_valid.
REQ-014 On a violation in LOCKED, act SHALL evaluate to 0 from the following cycle, so at most the violating cycle's sample is emitted.
REQ-015 Counter saturation (missing sync) SHALL NOT wrap; the next h_rise or v_rise check reports the mismatch.

Reset
REQ-016 While sys_rst_n = 0, all of the following SHALL be forced:
- state SEARCH, good = 0
- h_cnt, v_cnt, hs1, vs1, rgb1 = 0
- pix_valid, sof, locked, timing_err = 0
- pix_data = 0, pos_x = pos_y = 10'h3ff
REQ-017 After reset release (including mid-frame), the block SHALL resume in SEARCH and apply no checks until the first v_rise.

Verification
REQ-018 Reset, then standard 800x525 timing with hs=96 and vs=2 -> locked rises at the third v_rise (the LOCK_FRAMES=2 clean frames complete); no timing_err.
REQ-019 Locked; generator drives rgb=24'hA5A5A5 at cnt_h=144, cnt_v=35 -> two edges later pix_valid=1, pos_x=0, pos_y=0, sof=1, pix_data=A5A5A5.
REQ-020 Locked; one line of 801 pixels -> timing_err pulses one cycle on that h_rise; locked=0 and pix_valid=0 from the next cycle; relock after 2 clean frames.
REQ-021 TRAIN; hsync width 95 in frame 1 -> timing_err, good cleared; locking requires 2 further clean frames.
REQ-022 Locked; sys_rst_n pulsed low mid-line at cnt_h=400 -> all outputs at reset values immediately; locked only after a v_rise plus 2 clean frames.
REQ-023 hsync held low for 2000 cycles while locked -> h_cnt saturates at 1023; timing_err at the next h_rise; no pix_valid during the outage.
